// File: rtl/sbus_pkg.sv
// Shared definitions for the serial system bus arbiter and slave port.
package sbus_pkg;

  // FSM state encoding
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT_M1   = 2'd1,
    GRANT_M2   = 2'd2,
    TURNAROUND = 2'd3
  } state_e;

  // Owner codes driven on the owner output
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_M1   = 2'd1;
  localparam logic [1:0] OWN_M2   = 2'd2;

  // Serial field lengths shared with the slave port
  localparam int ADDR_BITS  = 12;
  localparam int DATA_BITS  = 8;
  localparam int BURST_BITS = 13;

  // Bit positions of the muxed lines inside a packed lane vector
  localparam int LN_ADDR  = 0;
  localparam int LN_DATA  = 1;
  localparam int LN_BURST = 2;
  localparam int LN_VALID = 3;
  localparam int LN_RD    = 4;
  localparam int LN_WR    = 5;
  localparam int NUM_LANES = 6;

endpackage

// File: rtl/sbus_lane_mux.sv
// 2:1 mux of the serial/control lines; forces all lanes low with no owner.
module sbus_lane_mux
  import sbus_pkg::*;
#(
  parameter int NUM_L = NUM_LANES
) (
  input  logic [1:0]       sel,
  input  logic [NUM_L-1:0] m1_lines,
  input  logic [NUM_L-1:0] m2_lines,
  output logic [NUM_L-1:0] bus_lines
);

  // Per-lane select; any non-owner code (none or turnaround) drives zero
  for (genvar i = 0; i < NUM_L; i++) begin : g_lane
    always_comb begin
      bus_lines[i] = 1'b0;
      if (sel == OWN_M1)      bus_lines[i] = m1_lines[i];
      else if (sel == OWN_M2) bus_lines[i] = m2_lines[i];
    end
  end

endmodule

// File: rtl/sbus_arbiter.sv
// Two-master round-robin arbiter for the shared serial system bus.
module sbus_arbiter
  import sbus_pkg::*;
#(
  parameter int HOLD_LIMIT = 64,
  parameter int CNT_W      = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m1_req,
  input  logic       m2_req,
  output logic       m1_grant,
  output logic       m2_grant,
  input  logic       m1_address,
  input  logic       m2_address,
  input  logic       m1_data,
  input  logic       m2_data,
  input  logic       m1_burst,
  input  logic       m2_burst,
  input  logic       m1_valid,
  input  logic       m2_valid,
  input  logic       m1_read_en,
  input  logic       m2_read_en,
  input  logic       m1_write_en,
  input  logic       m2_write_en,
  output logic       m1_ready,
  output logic       m2_ready,
  output logic       bus_address,
  output logic       bus_data,
  output logic       bus_burst,
  output logic       bus_valid,
  output logic       bus_read_en,
  output logic       bus_write_en,
  input  logic       slave_ready,
  output logic       bus_busy,
  output logic [1:0] owner
);

  localparam logic [CNT_W-1:0] LIM    = CNT_W'(HOLD_LIMIT);
  localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(HOLD_LIMIT - 1);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic             last_m2;   // 1: M2 owned last, so M1 wins next contention
  logic             granted;
  logic [NUM_LANES-1:0] m1_lines, m2_lines, bus_lines;

  assign granted = (state == GRANT_M1) || (state == GRANT_M2);

  // State, hold counter and round-robin history
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      last_m2  <= 1'b1;
    end else begin
      state <= state_nxt;
      // Counter runs only while the same grant persists; clears otherwise
      if (granted && state_nxt == state) begin
        if (hold_cnt != LIM) hold_cnt <= hold_cnt + 1'b1;
      end else begin
        hold_cnt <= '0;
      end
      if (state == GRANT_M1 && state_nxt != GRANT_M1) last_m2 <= 1'b0;
      if (state == GRANT_M2 && state_nxt != GRANT_M2) last_m2 <= 1'b1;
    end
  end

  // Next-state: arbitration in IDLE, release/preemption only when slave is ready
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m1_req && (!m2_req || last_m2)) state_nxt = GRANT_M1;
        else if (m2_req)                    state_nxt = GRANT_M2;
      end
      GRANT_M1: begin
        if (slave_ready && (!m1_req || (m2_req && hold_cnt >= LIM_M1)))
          state_nxt = TURNAROUND;
      end
      GRANT_M2: begin
        if (slave_ready && (!m2_req || (m1_req && hold_cnt >= LIM_M1)))
          state_nxt = TURNAROUND;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the registered state
  assign m1_grant = (state == GRANT_M1);
  assign m2_grant = (state == GRANT_M2);
  assign bus_busy = granted;
  assign owner    = m1_grant ? OWN_M1 : (m2_grant ? OWN_M2 : OWN_NONE);
  assign m1_ready = slave_ready & m1_grant;
  assign m2_ready = slave_ready & m2_grant;

  assign m1_lines = {m1_write_en, m1_read_en, m1_valid, m1_burst, m1_data, m1_address};
  assign m2_lines = {m2_write_en, m2_read_en, m2_valid, m2_burst, m2_data, m2_address};

  sbus_lane_mux #(.NUM_L(NUM_LANES)) u_mux (
    .sel       (owner),
    .m1_lines  (m1_lines),
    .m2_lines  (m2_lines),
    .bus_lines (bus_lines)
  );

  assign bus_address  = bus_lines[LN_ADDR];
  assign bus_data     = bus_lines[LN_DATA];
  assign bus_burst    = bus_lines[LN_BURST];
  assign bus_valid    = bus_lines[LN_VALID];
  assign bus_read_en  = bus_lines[LN_RD];
  assign bus_write_en = bus_lines[LN_WR];

endmodule
